// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, payload types and helpers for the VGA scan-out slice.
//   - VGA640_*  : 640x480@60 timing constants used as parameter defaults
//   - rgb_t     : 8-bit-per-channel {R,G,B} pixel payload
//   - side_t    : sideband bits carried alongside a pixel through the read pipeline
//   - frame_tot : total counts per line/frame from active + porches + sync
package vga_pkg;

  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Sync bits are "inside the sync region" (active-high); polarity is applied at the pins.
  typedef struct packed {
    logic frame_start;
    logic vsync;
    logic hsync;
    logic active;
  } side_t;

  function automatic int unsigned frame_tot(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running pixel/line counters and region decode.
//   clk, rst (sync, active-low)
//   hcnt, vcnt     : registered counters, active region starts at 0
//   active_c       : inside visible area
//   hsync_c/vsync_c: inside horizontal/vertical sync region (active-high, polarity-free)
//   frame_start_c  : counters at (0,0)
module vga_timing import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FP     = VGA640_H_FP,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BP     = VGA640_H_BP,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FP     = VGA640_V_FP,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BP     = VGA640_V_BP,
  localparam int unsigned H_TOT = frame_tot(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOT = frame_tot(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW    = $clog2(H_TOT),
  localparam int unsigned VW    = $clog2(V_TOT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active_c,
  output logic          hsync_c,
  output logic          vsync_c,
  output logic          frame_start_c
);

  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;

  // Raster counters; vcnt advances on the hcnt wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (32'(hcnt) == H_TOT - 1) begin
      hcnt <= '0;
      vcnt <= (32'(vcnt) == V_TOT - 1) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Region decode, compared at 32 bits so sync-end == total cannot alias to 0.
  always_comb begin
    active_c      = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
    hsync_c       = (32'(hcnt) >= HS_BEG) && (32'(hcnt) < HS_END);
    vsync_c       = (32'(vcnt) >= VS_BEG) && (32'(vcnt) < VS_END);
    frame_start_c = (hcnt == '0) && (vcnt == '0);
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA scan-out engine with framebuffer read-latency compensation.
//   clk, rst (sync, active-low)
//   fb_rd_en, fb_x, fb_y : registered framebuffer read request (replicated by 2^SCALE_LOG2)
//   fb_data              : {R,G,B}, valid RD_LAT cycles after the request
//   hsync, vsync         : sync at HS_POL / VS_POL
//   valid                : active video
//   vga_r/g/b            : pixel colour, 0 while blanked
//   frame_start          : pulse aligned with pixel (0,0)
//   tp_en                : colour-bar test pattern, only with VGA_SCANOUT_TESTPAT_EN defined
module vga_scanout import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int unsigned H_FP       = VGA640_H_FP,
  parameter int unsigned H_SYNC     = VGA640_H_SYNC,
  parameter int unsigned H_BP       = VGA640_H_BP,
  parameter int unsigned V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int unsigned V_FP       = VGA640_V_FP,
  parameter int unsigned V_SYNC     = VGA640_V_SYNC,
  parameter int unsigned V_BP       = VGA640_V_BP,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned SCALE_LOG2 = 0,
  localparam int unsigned HW = $clog2(frame_tot(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int unsigned VW = $clog2(frame_tot(V_ACTIVE, V_FP, V_SYNC, V_BP)),
  localparam int unsigned XW = $clog2(H_ACTIVE >> SCALE_LOG2),
  localparam int unsigned YW = $clog2(V_ACTIVE >> SCALE_LOG2),
  localparam int unsigned PW = 3 * COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
`ifdef VGA_SCANOUT_TESTPAT_EN
  input  logic               tp_en,
`endif
  output logic               fb_rd_en,
  output logic [XW-1:0]      fb_x,
  output logic [YW-1:0]      fb_y,
  input  logic [PW-1:0]      fb_data,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               frame_start
);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active_c;
  logic          hsync_c;
  logic          vsync_c;
  logic          frame_start_c;
  logic [PW-1:0] pix_c;

  // dly[0] is captured with the read request; dly[RD_LAT] lines up with fb_data.
  side_t         dly [RD_LAT+1];

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .hcnt          (hcnt),
    .vcnt          (vcnt),
    .active_c      (active_c),
    .hsync_c       (hsync_c),
    .vsync_c       (vsync_c),
    .frame_start_c (frame_start_c)
  );

  // Read stage: scaled address re-reads the same location for replicated pixels/lines.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fb_rd_en <= 1'b0;
      fb_x     <= '0;
      fb_y     <= '0;
    end else begin
      fb_rd_en <= active_c;
      fb_x     <= XW'(hcnt >> SCALE_LOG2);
      fb_y     <= YW'(vcnt >> SCALE_LOG2);
    end
  end

  // Sideband delay line matching the framebuffer read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= int'(RD_LAT); i++) dly[i] <= '0;
    end else begin
      dly[0] <= '{frame_start: frame_start_c, vsync: vsync_c, hsync: hsync_c, active: active_c};
      for (int i = 1; i <= int'(RD_LAT); i++) dly[i] <= dly[i-1];
    end
  end

`ifdef VGA_SCANOUT_TESTPAT_EN
  localparam int unsigned BAR_LSB = $clog2(H_ACTIVE) - 3;
  logic [2:0] bar_dly [RD_LAT+1];

  // Bar index taken from the top three bits of the visible column range.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= int'(RD_LAT); i++) bar_dly[i] <= '0;
    end else begin
      bar_dly[0] <= 3'(hcnt >> BAR_LSB);
      for (int i = 1; i <= int'(RD_LAT); i++) bar_dly[i] <= bar_dly[i-1];
    end
  end
`endif

  // Pixel source select.
  always_comb begin
    pix_c = fb_data;
`ifdef VGA_SCANOUT_TESTPAT_EN
    if (tp_en) begin
      pix_c = {{COLOR_W{bar_dly[RD_LAT][2]}}, {COLOR_W{bar_dly[RD_LAT][1]}},
               {COLOR_W{bar_dly[RD_LAT][0]}}};
    end
`endif
  end

  // Output stage: polarity, blanking, registered pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      hsync       <= dly[RD_LAT].hsync ? HS_POL : ~HS_POL;
      vsync       <= dly[RD_LAT].vsync ? VS_POL : ~VS_POL;
      valid       <= dly[RD_LAT].active;
      frame_start <= dly[RD_LAT].frame_start;
      vga_r       <= dly[RD_LAT].active ? pix_c[PW-1 -: COLOR_W]        : '0;
      vga_g       <= dly[RD_LAT].active ? pix_c[2*COLOR_W-1 -: COLOR_W] : '0;
      vga_b       <= dly[RD_LAT].active ? pix_c[COLOR_W-1:0]            : '0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: three scan-out configurations on a small 8x4 raster, each fed by a
// model framebuffer ({x,y,x^y}, random data when not read), checked every cycle against
// an arithmetic raster model plus literal frame statistics.
module tb_vga_scanout;

  localparam int NCFG = 3;
  localparam int unsigned LAT [NCFG] = '{1, 3, 0};
  localparam int unsigned SCL [NCFG] = '{0, 1, 0};
  localparam logic        POL [NCFG] = '{1'b0, 1'b1, 1'b0};
  localparam int HT  = 14;
  localparam int VT  = 7;
  localparam int PER = HT * VT;

  typedef struct packed {
    logic        rd_en;
    logic [3:0]  fx;
    logic [3:0]  fy;
    logic        hs;
    logic        vs;
    logic        vl;
    logic        fs;
    logic [23:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tp_en = 1'b0;
  logic tp_q = 1'b0;
  logic started = 1'b0;
  int   n_rel = -1;
  int   nchk = 0;
  int   npass = 0;

  logic        rd_en [NCFG];
  logic [3:0]  fx    [NCFG];
  logic [3:0]  fy    [NCFG];
  logic        hs    [NCFG];
  logic        vs    [NCFG];
  logic        vl    [NCFG];
  logic        fs    [NCFG];
  logic [23:0] rgb   [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int unsigned XW = $clog2(8 >> SCL[g]);
    localparam int unsigned YW = $clog2(4 >> SCL[g]);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          en;
    logic [23:0]   data;
    logic [23:0]   cur;
    logic [23:0]   junk;
    logic [23:0]   pipe [4];
    logic [7:0]    cr, cg, cb;

    vga_scanout #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HS_POL (POL[g]), .VS_POL (POL[g]), .COLOR_W (8),
      .RD_LAT (LAT[g]), .SCALE_LOG2 (SCL[g])
    ) dut (
`ifdef VGA_SCANOUT_TESTPAT_EN
      .tp_en       (tp_en),
`endif
      .clk         (clk),
      .rst         (rst),
      .fb_rd_en    (en),
      .fb_x        (x),
      .fb_y        (y),
      .fb_data     (data),
      .hsync       (hs[g]),
      .vsync       (vs[g]),
      .valid       (vl[g]),
      .vga_r       (cr),
      .vga_g       (cg),
      .vga_b       (cb),
      .frame_start (fs[g])
    );

    // Framebuffer model with fixed read latency.
    always @(posedge clk) junk <= 24'($urandom);
    always_comb cur = en ? {8'(x), 8'(y), 8'(x) ^ 8'(y)} : junk;
    always @(posedge clk) begin
      pipe[0] <= cur;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    if (LAT[g] == 0) begin : comb_rd
      assign data = cur;
    end else begin : seq_rd
      assign data = pipe[LAT[g]-1];
    end

    assign rd_en[g] = en;
    assign fx[g]    = 4'(x);
    assign fy[g]    = 4'(y);
    assign rgb[g]   = {cr, cg, cb};
  end

  // Expected pins n edges after reset release (n < 0: in reset).
  function automatic obs_t model(input int c, input int n, input logic tp);
    obs_t e;
    int p, h, v, k;
    logic [2:0] bar;
    e = '0;
    e.hs = ~POL[c];
    e.vs = ~POL[c];
    if (n < 0) return e;
    p = n % PER; h = p % HT; v = p / HT;
    e.rd_en = (h < 8) && (v < 4);
    if (e.rd_en) begin
      e.fx = 4'(h >> SCL[c]);
      e.fy = 4'(v >> SCL[c]);
    end
    k = n - int'(LAT[c]) - 1;
    if (k < 0) return e;
    p = k % PER; h = p % HT; v = p / HT;
    e.hs = (h >= 10 && h < 12) ? POL[c] : ~POL[c];
    e.vs = (v == 5) ? POL[c] : ~POL[c];
    e.vl = (h < 8) && (v < 4);
    e.fs = (p == 0);
    if (e.vl) begin
      bar = 3'(h);
      if (tp) e.rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      else    e.rgb = {8'(h >> SCL[c]), 8'(v >> SCL[c]), 8'(h >> SCL[c]) ^ 8'(v >> SCL[c])};
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s cfg%0d: got %0h expected %0h", nm, c, act, exp);
  endtask

  always @(posedge clk) begin
    started <= 1'b1;
    tp_q    <= tp_en;
    n_rel   <= rst ? n_rel + 1 : -1;
  end

  obs_t e;
  int   hs_lo, vs_lo, vl_hi, fs_cnt, last_fs;
  logic seen_fs;

  // Per-cycle comparison against the model, plus literal frame statistics.
  always @(negedge clk) begin
    if (started) begin
      for (int c = 0; c < NCFG; c++) begin
        e = model(c, n_rel, tp_q);
        chk("rd_en", c, 32'(rd_en[c]), 32'(e.rd_en));
        if (e.rd_en) begin
          chk("fb_x", c, 32'(fx[c]), 32'(e.fx));
          chk("fb_y", c, 32'(fy[c]), 32'(e.fy));
        end
        chk("hsync", c, 32'(hs[c]), 32'(e.hs));
        chk("vsync", c, 32'(vs[c]), 32'(e.vs));
        chk("valid", c, 32'(vl[c]), 32'(e.vl));
        chk("frame_start", c, 32'(fs[c]), 32'(e.fs));
        chk("rgb", c, 32'(rgb[c]), 32'(e.rgb));
      end
      if (n_rel < 0) begin
        hs_lo = 0; vs_lo = 0; vl_hi = 0; fs_cnt = 0; last_fs = -1; seen_fs = 1'b0;
        chk("rst_hsync_pol1", 1, 32'(hs[1]), 32'd0);
        chk("rst_vsync_pol1", 1, 32'(vs[1]), 32'd0);
      end else begin
        if (n_rel >= 2 && n_rel < 2 + PER) begin
          if (hs[0] === 1'b0) hs_lo++;
          if (vs[0] === 1'b0) vs_lo++;
          if (vl[0] === 1'b1) vl_hi++;
          if (fs[0] === 1'b1) fs_cnt++;
        end
        if (n_rel == 1 + PER) begin
          chk("hsync_low_per_frame", 0, 32'(hs_lo), 32'd14);
          chk("vsync_low_per_frame", 0, 32'(vs_lo), 32'd14);
          chk("valid_per_frame", 0, 32'(vl_hi), 32'd32);
          chk("fs_per_frame", 0, 32'(fs_cnt), 32'd1);
        end
        if (fs[0] === 1'b1) begin
          if (!seen_fs) chk("first_fs_latency", 0, 32'(n_rel), 32'd2);
          else          chk("fs_period", 0, 32'(n_rel - last_fs), 32'd98);
          seen_fs = 1'b1;
          last_fs = n_rel;
        end
        if (n_rel == 3) begin
          chk("scale_x_h3", 1, 32'(fx[1]), 32'd1);
          chk("scale_rd_h3", 1, 32'(rd_en[1]), 32'd1);
        end
        if (n_rel == 14) chk("scale_y_line1", 1, 32'(fy[1]), 32'd0);
        if (n_rel == 30) chk("scale_y_line2", 1, 32'(fy[1]), 32'd1);
      end
    end
  end

  initial begin
    rst   = 1'b0;
    tp_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    // Edge 229 after release lands on vcnt=2, hcnt=5 of the third frame.
    repeat (229) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (250) @(negedge clk);
`ifdef VGA_SCANOUT_TESTPAT_EN
    tp_en = 1'b1;
    repeat (PER) @(negedge clk);
    tp_en = 1'b0;
    repeat (20) @(negedge clk);
`endif
    #1;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised VGA scan-out engine: generates pixel timing for any resolution, issues framebuffer read addresses, and returns aligned sync/blank/RGB to the board VGA pins. It sits between the top level and an external framebuffer memory with a fixed, known read latency. It adds configurable resolution, colour depth, sync polarity, integer pixel replication (scaling) and read-latency compensation. It replaces the fixed 640x480 controller and its combinational memory lookup.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480: visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical front porch / sync / back porch, in lines
- HS_POL / VS_POL, 0 / 0: active level of the sync pulses
- COLOR_W, 8: bits per colour channel
- RD_LAT, 1: framebuffer read latency in cycles (0..4)
- SCALE_LOG2, 0: pixel replication factor 2^SCALE_LOG2 in both axes (0..2)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-low reset
- fb_rd_en  out  1  framebuffer read strobe
- fb_x  out  $clog2(H_ACTIVE>>SCALE_LOG2)  framebuffer column
- fb_y  out  $clog2(V_ACTIVE>>SCALE_LOG2)  framebuffer row
- fb_data  in  3*COLOR_W  {R,G,B}; valid RD_LAT cycles after fb_rd_en
- hsync, vsync  out  1  sync outputs at HS_POL / VS_POL
- valid  out  1  active video (VGA_BLANK_N)
- vga_r, vga_g, vga_b  out  COLOR_W each  pixel colour, 0 while blanked
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the outputs

## Operation
- Counters: hcnt runs 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP. vcnt increments when hcnt wraps, runs 0..V_TOT-1, and wraps to 0.
- Region order per line and per frame: active, front porch, sync, back porch. Active region starts at count 0.
- Horizontal sync is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Vertical sync uses the same rule on vcnt.
- Read stage:
  - fb_rd_en = (hcnt<H_ACTIVE && vcnt<V_ACTIVE).
  - fb_x = hcnt>>SCALE_LOG2 and fb_y = vcnt>>SCALE_LOG2.
  - All three are registered from the counters.
- Alignment: hsync, vsync, valid and frame_start pass through a delay line of RD_LAT stages, so they line up with the returning fb_data.
- Output stage (registered): vga_* = valid_d ? fb_data : 0.
- Scaling: with SCALE_LOG2=1, each fb_x repeats for 2 consecutive pixels and each fb_y for 2 consecutive lines. The same address is re-read; no line buffer is used.
- Mid-frame reset: the current frame is abandoned immediately and the next frame starts cleanly from (0,0).

## Timing
- Reset (rst=0 at a clk edge):
  - hcnt=vcnt=0.
  - fb_rd_en, valid, frame_start and vga_* all 0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - All delay stages are cleared.
- The first edge with rst=1 is cycle 0. fb_rd_en=1 with fb_x=fb_y=0 is visible after cycle 0.
- Latency from counter state to pins is RD_LAT+1 cycles for all outputs.
- Fixed latency:
  - Pixel (0,0) appears on the outputs RD_LAT+1 cycles after fb_rd_en for (0,0) is first seen.
  - The sync outputs keep the same fixed offset.
- Frame period is exactly H_TOT*V_TOT cycles. The pipeline never stalls and fb_data has no handshake.

## Configuration
- VGA_SCANOUT_TESTPAT_EN defined:
  - Adds input port tp_en (1 bit).
  - While tp_en=1, the output stage replaces fb_data with 8 vertical colour bars, selected by the delayed hcnt[top 3 bits of H_ACTIVE range].
  - Bar i has R=i[2], G=i[1], B=i[0], each replicated to COLOR_W bits.
  - fb_rd_en still toggles normally.
- Undefined: the port is absent and only fb_data is used.

## Structure
- Package vga_pkg holds:
  - the 640x480@60 timing constants
  - the RGB struct type
  - an H_TOT/V_TOT helper function
- Sub-module vga_timing contains the hcnt/vcnt counters, the region decode and the raw sync/active/frame_start signals.
- vga_scanout contains the address register, the RD_LAT delay line, the blanking mux and the test-pattern logic.

## Test plan
Small geometry for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1.
- Reset then free-run with RD_LAT=1 and a model memory (data = {x,y,x^y}):
  - frame_start period is 98 cycles.
  - hsync is low for 2 of every 14 cycles.
  - vsync is low for 14 cycles per frame.
  - valid is high for 32 cycles per frame.
- Alignment with RD_LAT=0, 1, 3: each valid pixel equals memory[fb_x,fb_y] from RD_LAT+1 cycles earlier. vga_*=0 whenever valid=0.
- SCALE_LOG2=1: per line, fb_x sequence is 0,0,1,1,2,2,3,3. Lines 0 and 1 both show fb_y=0.
- HS_POL=1 and VS_POL=1: sync outputs are inverted relative to the default. Reset values are hsync=0 and vsync=0.
- Reset asserted mid-frame (vcnt=2, hcnt=5):
  - The next cycle shows all outputs at their reset values.
  - After release, frame_start arrives RD_LAT+1 cycles later.
- VGA_SCANOUT_TESTPAT_EN with tp_en=1 and COLOR_W=8: the active pixels of a line show bars 0..7, each one pixel wide (000000, 0000FF, 00FF00, ...).
